// File: rtl/header_adder_arbiter.sv
// Packet-granular round-robin arbiter that shares one header adder between PORTS streams.
// A port is picked in IDLE (one cycle of latency) and keeps the grant until its tlast beat.

module header_adder_arbiter #(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 128,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int HDR_WIDTH  = 64,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 8,
  parameter int ID_WIDTH   = $clog2(PORTS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [PORTS-1:0]                 port_en,
  input  logic [PORTS*DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [PORTS*STRB_WIDTH-1:0]      s_axis_tkeep,
  input  logic [PORTS*DEST_WIDTH-1:0]      s_axis_tdest,
  input  logic [PORTS*USER_WIDTH-1:0]      s_axis_tuser,
  input  logic [PORTS-1:0]                 s_axis_tlast,
  input  logic [PORTS-1:0]                 s_axis_tvalid,
  output logic [PORTS-1:0]                 s_axis_tready,
  input  logic [PORTS*HDR_WIDTH-1:0]       s_header,
  input  logic [PORTS-1:0]                 s_header_valid,
  output logic [PORTS-1:0]                 s_header_ready,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [STRB_WIDTH-1:0]            m_axis_tkeep,
  output logic [DEST_WIDTH-1:0]            m_axis_tdest,
  output logic [USER_WIDTH-1:0]            m_axis_tuser,
  output logic                             m_axis_tlast,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic [ID_WIDTH-1:0]              m_axis_tid,
  output logic [HDR_WIDTH-1:0]             m_header,
  output logic                             m_header_valid,
  input  logic                             m_header_ready
);

  localparam int CW = ID_WIDTH + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   grant_q, grant_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic                  first_q, first_d;

  logic [PORTS-1:0]      req_s;
  logic                  pick_found_s;
  logic [ID_WIDTH-1:0]   pick_idx_s;
  logic [CW-1:0]         scan_sum_s;
  logic [ID_WIDTH-1:0]   scan_idx_s;
  logic                  beat_s;

  logic [DATA_WIDTH-1:0] data_arr_s [PORTS];
  logic [STRB_WIDTH-1:0] keep_arr_s [PORTS];
  logic [DEST_WIDTH-1:0] dest_arr_s [PORTS];
  logic [USER_WIDTH-1:0] user_arr_s [PORTS];
  logic [HDR_WIDTH-1:0]  hdr_arr_s  [PORTS];

  for (genvar i = 0; i < PORTS; i++) begin : g_unpack
    assign data_arr_s[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    assign keep_arr_s[i] = s_axis_tkeep[i*STRB_WIDTH +: STRB_WIDTH];
    assign dest_arr_s[i] = s_axis_tdest[i*DEST_WIDTH +: DEST_WIDTH];
    assign user_arr_s[i] = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
    assign hdr_arr_s[i]  = s_header[i*HDR_WIDTH +: HDR_WIDTH];
  end

  assign req_s = s_axis_tvalid & port_en;

  // Data path is a pure mux on the held grant; validity is gated by the FSM below.
  assign m_axis_tdata = data_arr_s[grant_q];
  assign m_axis_tkeep = keep_arr_s[grant_q];
  assign m_axis_tdest = dest_arr_s[grant_q];
  assign m_axis_tuser = user_arr_s[grant_q];
  assign m_axis_tlast = s_axis_tlast[grant_q];
  assign m_header     = hdr_arr_s[grant_q];
  assign m_axis_tid   = grant_q;

  // Round-robin scan: first requester at or after rr_ptr, wrapping PORTS-1 -> 0.
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = '0;
    scan_sum_s   = '0;
    scan_idx_s   = '0;
    for (int k = 0; k < PORTS; k++) begin
      scan_sum_s = {1'b0, rr_ptr_q} + CW'(k);
      scan_idx_s = (scan_sum_s >= CW'(PORTS)) ? ID_WIDTH'(scan_sum_s - CW'(PORTS))
                                               : scan_sum_s[ID_WIDTH-1:0];
      if (!pick_found_s && req_s[scan_idx_s]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = scan_idx_s;
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // Grant FSM: next state plus ready/valid steering for the granted port.
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    rr_ptr_d       = rr_ptr_q;
    first_d        = first_q;
    s_axis_tready  = '0;
    s_header_ready = '0;
    m_axis_tvalid  = 1'b0;
    m_header_valid = 1'b0;
    beat_s         = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found_s) begin
          grant_d = pick_idx_s;
          first_d = 1'b1;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        m_axis_tvalid             = s_axis_tvalid[grant_q];
        s_axis_tready[grant_q]    = m_axis_tready;
        s_header_ready[grant_q]   = m_header_ready && first_q;
        m_header_valid            = first_q && s_header_valid[grant_q];
        beat_s                    = s_axis_tvalid[grant_q] && m_axis_tready;
        if (beat_s) begin
          first_d = 1'b0;
          if (s_axis_tlast[grant_q]) begin
            state_d  = IDLE;
            rr_ptr_d = (grant_q == ID_WIDTH'(PORTS - 1)) ? '0 : grant_q + ID_WIDTH'(1);
          end else begin
            state_d = BUSY;
          end
        end else begin
          state_d = BUSY;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; an asserted reset abandons any packet in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      first_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      first_q  <= first_d;
    end
  end

endmodule

// File: tb/tb_header_adder_arbiter.sv
// Scoreboard bench for header_adder_arbiter: per-port packet sources, expected beats queued
// in the order round-robin should serve them, plus a 3-port instance for the wrap case.

module tb_header_adder_arbiter;

  localparam int P  = 4;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int HW = 16;
  localparam int DSW = 8;
  localparam int UW = 8;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [P-1:0]     port_en;
  logic [P*DW-1:0]  s_tdata;
  logic [P*SW-1:0]  s_tkeep;
  logic [P*DSW-1:0] s_tdest;
  logic [P*UW-1:0]  s_tuser;
  logic [P-1:0]     s_tlast, s_tvalid, s_tready;
  logic [P*HW-1:0]  s_hdr;
  logic [P-1:0]     s_hvalid, s_hready;
  logic [DW-1:0]    m_tdata;
  logic [SW-1:0]    m_tkeep;
  logic [DSW-1:0]   m_tdest;
  logic [UW-1:0]    m_tuser;
  logic             m_tlast, m_tvalid, m_tready;
  logic [IW-1:0]    m_tid;
  logic [HW-1:0]    m_hdr;
  logic             m_hvalid, m_hready;

  header_adder_arbiter #(.PORTS(P), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .HDR_WIDTH(HW),
                         .DEST_WIDTH(DSW), .USER_WIDTH(UW)) u_dut (
    .clk(clk), .rst(rst), .port_en(port_en),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tdest(s_tdest),
    .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_header(s_hdr), .s_header_valid(s_hvalid),
    .s_header_ready(s_hready), .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep),
    .m_axis_tdest(m_tdest), .m_axis_tuser(m_tuser), .m_axis_tlast(m_tlast),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tid(m_tid),
    .m_header(m_hdr), .m_header_valid(m_hvalid), .m_header_ready(m_hready)
  );

  logic [2:0]     p3_en, s3_tlast, s3_tvalid, s3_tready, s3_hvalid, s3_hready;
  logic [3*DW-1:0]  s3_tdata;
  logic [3*SW-1:0]  s3_tkeep;
  logic [3*DSW-1:0] s3_tdest;
  logic [3*UW-1:0]  s3_tuser;
  logic [3*HW-1:0]  s3_hdr;
  logic [DW-1:0]  m3_tdata;
  logic [SW-1:0]  m3_tkeep;
  logic [DSW-1:0] m3_tdest;
  logic [UW-1:0]  m3_tuser;
  logic           m3_tlast, m3_tvalid, m3_tready, m3_hvalid, m3_hready;
  logic [1:0]     m3_tid;
  logic [HW-1:0]  m3_hdr;

  header_adder_arbiter #(.PORTS(3), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .HDR_WIDTH(HW),
                         .DEST_WIDTH(DSW), .USER_WIDTH(UW)) u_dut3 (
    .clk(clk), .rst(rst), .port_en(p3_en),
    .s_axis_tdata(s3_tdata), .s_axis_tkeep(s3_tkeep), .s_axis_tdest(s3_tdest),
    .s_axis_tuser(s3_tuser), .s_axis_tlast(s3_tlast), .s_axis_tvalid(s3_tvalid),
    .s_axis_tready(s3_tready), .s_header(s3_hdr), .s_header_valid(s3_hvalid),
    .s_header_ready(s3_hready), .m_axis_tdata(m3_tdata), .m_axis_tkeep(m3_tkeep),
    .m_axis_tdest(m3_tdest), .m_axis_tuser(m3_tuser), .m_axis_tlast(m3_tlast),
    .m_axis_tvalid(m3_tvalid), .m_axis_tready(m3_tready), .m_axis_tid(m3_tid),
    .m_header(m3_hdr), .m_header_valid(m3_hvalid), .m_header_ready(m3_hready)
  );

  typedef struct {
    logic [IW-1:0]  tid;
    logic [DW-1:0]  data;
    logic [SW-1:0]  keep;
    logic [DSW-1:0] dest;
    logic [UW-1:0]  user;
    logic           last;
    logic           hv;
    logic [HW-1:0]  hdr;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int beats = 0;
  logic beat_now;
  int last_tid;
  int hr_cnt [P];
  logic [P-1:0] rdy_seen;

  // Packet sources: npk packets of plen beats remaining per port
  int npk [P], plen [P], bt [P], pid [P];

  task automatic drive();
    for (int p = 0; p < P; p++) begin
      s_tdata[p*DW +: DW]   = {8'(p), 8'(pid[p]), 16'(bt[p])};
      s_tkeep[p*SW +: SW]   = 4'(bt[p] ^ p) | 4'b0001;
      s_tdest[p*DSW +: DSW] = 8'(8'h10 + p);
      s_tuser[p*UW +: UW]   = 8'(pid[p]);
      s_hdr[p*HW +: HW]     = {8'(8'hA0 + p), 8'(pid[p])};
      s_tvalid[p]           = (npk[p] > 0);
      s_hvalid[p]           = (npk[p] > 0);
      s_tlast[p]            = (npk[p] > 0) && (bt[p] == plen[p] - 1);
    end
  endtask

  task automatic clear_src();
    for (int p = 0; p < P; p++) begin
      npk[p] = 0; plen[p] = 1; bt[p] = 0; pid[p] = 0;
    end
  endtask

  task automatic start_src(input int p, input int n, input int len);
    npk[p] = n; plen[p] = len; bt[p] = 0;
  endtask

  task automatic push_pkt(input int p, input int pv, input int len);
    exp_t e;
    for (int b = 0; b < len; b++) begin
      e.tid  = IW'(p);
      e.data = {8'(p), 8'(pv), 16'(b)};
      e.keep = 4'(b ^ p) | 4'b0001;
      e.dest = 8'(8'h10 + p);
      e.user = 8'(pv);
      e.last = (b == len - 1);
      e.hv   = (b == 0);
      e.hdr  = {8'(8'hA0 + p), 8'(pv)};
      exp_q.push_back(e);
    end
  endtask

  // One clock: sample and score at negedge, advance sources just after posedge
  task automatic tick();
    logic [P-1:0] fire;
    exp_t e;
    @(negedge clk);
    fire = rst ? '0 : (s_tvalid & s_tready);
    beat_now = 1'b0;
    if (!rst && m_tvalid && m_tready) begin
      beat_now = 1'b1;
      beats++;
      last_tid = int'(m_tid);
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got beat tid=%0d data=%h, expected no beat", m_tid, m_tdata);
      end else begin
        e = exp_q.pop_front();
        if ({m_tid, m_tdata, m_tkeep, m_tdest, m_tuser, m_tlast, m_hvalid} !==
            {e.tid, e.data, e.keep, e.dest, e.user, e.last, e.hv} || (e.hv && m_hdr !== e.hdr)) begin
          n_err++;
          $display("FAIL sb_beat: got tid=%0d data=%h keep=%h last=%b hv=%b hdr=%h, expected tid=%0d data=%h keep=%h last=%b hv=%b hdr=%h",
                   m_tid, m_tdata, m_tkeep, m_tlast, m_hvalid, m_hdr,
                   e.tid, e.data, e.keep, e.last, e.hv, e.hdr);
        end
      end
    end
    for (int p = 0; p < P; p++) if (s_hready[p]) hr_cnt[p]++;
    rdy_seen |= s_tready;
    cyc++;
    @(posedge clk);
    #1;
    for (int p = 0; p < P; p++) begin
      if (fire[p]) begin
        if (bt[p] == plen[p] - 1) begin
          bt[p] = 0; pid[p]++; npk[p]--;
        end else begin
          bt[p]++;
        end
      end
    end
    drive();
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    clear_src();
    drive();
    port_en = 4'hF;
    m_tready = 1'b1;
    m_hready = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    beats = 0;
    rdy_seen = '0;
    for (int p = 0; p < P; p++) hr_cnt[p] = 0;
    #1;
  endtask

  task automatic test_reset();
    clear_src();
    start_src(1, 1, 2);
    drive();
    @(negedge clk);
    n_cmp++;
    if ({s_tready, s_hready, m_tvalid, m_hvalid, m_tid} !== {4'h0, 4'h0, 1'b0, 1'b0, 2'd0}) begin
      n_err++;
      $display("FAIL reset_outputs: got tready=%b hready=%b tvalid=%b hvalid=%b tid=%0d, expected all 0",
               s_tready, s_hready, m_tvalid, m_hvalid, m_tid);
    end
  endtask

  task automatic test_single_packet();
    int t0;
    apply_reset();
    start_src(2, 1, 3);
    push_pkt(2, 0, 3);
    drive();
    t0 = cyc;
    tick();
    n_cmp++;
    if (beats !== 0) begin n_err++; $display("FAIL single_idle: got %0d beats, expected 0", beats); end
    while (beats < 3 && cyc - t0 < 20) tick();
    n_cmp++;
    if (cyc - t0 !== 4) begin n_err++; $display("FAIL single_cycles: got %0d, expected 4", cyc - t0); end
    repeat (3) tick();
    n_cmp++;
    if (exp_q.size() !== 0 || beats !== 3) begin
      n_err++; $display("FAIL single_drain: got %0d left %0d beats, expected 0 left 3 beats", exp_q.size(), beats);
    end
    n_cmp++;
    if (hr_cnt[2] !== 1 || hr_cnt[0] + hr_cnt[1] + hr_cnt[3] !== 0 || rdy_seen !== 4'b0100) begin
      n_err++;
      $display("FAIL single_hdr_ready: got hr2=%0d others=%0d rdy=%b, expected 1 0 0100",
               hr_cnt[2], hr_cnt[0] + hr_cnt[1] + hr_cnt[3], rdy_seen);
    end
  endtask

  task automatic test_round_robin();
    int t0, prev, gap_bad;
    apply_reset();
    for (int p = 0; p < P; p++) start_src(p, 2, 1);
    for (int k = 0; k < 2; k++) for (int p = 0; p < P; p++) push_pkt(p, k, 1);
    drive();
    t0 = cyc; prev = -1; gap_bad = 0;
    while (beats < 8 && cyc - t0 < 60) begin
      tick();
      if (beat_now) begin
        if (prev >= 0 && cyc - prev != 2) gap_bad++;
        prev = cyc;
      end
    end
    n_cmp++;
    if (beats !== 8 || cyc - t0 !== 16) begin
      n_err++; $display("FAIL rr_count: got %0d beats in %0d cycles, expected 8 in 16", beats, cyc - t0);
    end
    n_cmp++;
    if (gap_bad !== 0) begin n_err++; $display("FAIL rr_spacing: got %0d bad gaps, expected 0", gap_bad); end
  endtask

  task automatic test_wrap();
    logic [2:0] vld_tbl [3];
    int tid_tbl [3];
    int g;
    logic found;
    vld_tbl[0] = 3'b010; vld_tbl[1] = 3'b101; vld_tbl[2] = 3'b001;
    tid_tbl[0] = 1; tid_tbl[1] = 2; tid_tbl[2] = 0;
    apply_reset();
    p3_en = 3'b111; s3_tlast = 3'b111; s3_hvalid = 3'b111;
    m3_tready = 1'b1; m3_hready = 1'b1;
    s3_tdata = {32'hCCCC_0002, 32'hCCCC_0001, 32'hCCCC_0000};
    for (int k = 0; k < 3; k++) begin
      s3_tvalid = vld_tbl[k];
      g = 0; found = 1'b0;
      while (!found && g < 10) begin
        @(negedge clk);
        if (m3_tvalid && m3_tready) found = 1'b1;
        g++;
      end
      n_cmp++;
      if (!found || int'(m3_tid) != tid_tbl[k] || m3_tdata !== {16'hCCCC, 16'(tid_tbl[k])} || m3_hvalid !== 1'b1) begin
        n_err++;
        $display("FAIL wrap_grant%0d: got found=%b tid=%0d data=%h hv=%b, expected tid=%0d",
                 k, found, m3_tid, m3_tdata, m3_hvalid, tid_tbl[k]);
      end
      @(posedge clk);
      #1;
    end
    s3_tvalid = 3'b000;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] held;
    int stall_bad, g;
    apply_reset();
    start_src(1, 1, 6);
    push_pkt(1, 0, 6);
    drive();
    tick();
    start_src(3, 1, 2); start_src(0, 1, 2);
    push_pkt(3, 0, 2); push_pkt(0, 0, 2);
    drive();
    tick(); tick();
    n_cmp++;
    if (beats !== 2) begin n_err++; $display("FAIL bp_prestall: got %0d beats, expected 2", beats); end
    m_tready = 1'b0;
    #1;
    held = m_tdata;
    stall_bad = 0;
    repeat (5) begin
      tick();
      if (m_tvalid !== 1'b1 || m_tid !== 2'd1 || m_tdata !== held || s_tready !== 4'h0 || s_hready !== 4'h0)
        stall_bad++;
    end
    n_cmp++;
    if (stall_bad !== 0 || beats !== 2 || held !== {8'd1, 8'd0, 16'd2}) begin
      n_err++; $display("FAIL bp_hold: got %0d bad cycles, %0d beats, held=%h, expected 0, 2, 01000002", stall_bad, beats, held);
    end
    m_tready = 1'b1;
    g = 0;
    while (exp_q.size() != 0 && g < 40) begin tick(); g++; end
    repeat (2) tick();
    n_cmp++;
    if (exp_q.size() !== 0 || beats !== 10) begin
      n_err++; $display("FAIL bp_resume: got %0d left %0d beats, expected 0 left 10 beats", exp_q.size(), beats);
    end
  endtask

  task automatic test_port_enable();
    apply_reset();
    port_en = 4'b1101;
    start_src(1, 1, 2);
    start_src(3, 2, 3);
    push_pkt(3, 0, 3);
    drive();
    tick(); tick();
    n_cmp++;
    if (beats !== 1 || last_tid !== 3) begin
      n_err++; $display("FAIL en_first: got %0d beats tid=%0d, expected 1 beat tid=3", beats, last_tid);
    end
    port_en = 4'b0101;
    repeat (12) tick();
    n_cmp++;
    if (beats !== 3 || exp_q.size() !== 0 || rdy_seen[1] !== 1'b0) begin
      n_err++; $display("FAIL en_complete: got %0d beats %0d left rdy=%b, expected 3 beats 0 left port1 never ready",
                        beats, exp_q.size(), rdy_seen);
    end
  endtask

  task automatic test_reset_mid_packet();
    int g, first_tid;
    apply_reset();
    start_src(2, 1, 1);
    push_pkt(2, 0, 1);
    drive();
    g = 0;
    while (beats < 1 && g < 10) begin tick(); g++; end
    start_src(0, 1, 4);
    push_pkt(0, 0, 4);
    drive();
    while (beats < 3 && g < 30) begin tick(); g++; end
    n_cmp++;
    if (beats !== 3 || m_tvalid !== 1'b1) begin
      n_err++; $display("FAIL rst_prebeats: got %0d beats tvalid=%b, expected 3 and 1", beats, m_tvalid);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({s_tready, s_hready, m_tvalid, m_hvalid, m_tid} !== {4'h0, 4'h0, 1'b0, 1'b0, 2'd0}) begin
      n_err++;
      $display("FAIL rst_immediate: got tready=%b hready=%b tvalid=%b hvalid=%b tid=%0d, expected all 0",
               s_tready, s_hready, m_tvalid, m_hvalid, m_tid);
    end
    exp_q.delete();
    clear_src();
    drive();
    @(posedge clk);
    #1;
    rst = 1'b0;
    beats = 0;
    start_src(0, 1, 1); start_src(3, 1, 1);
    push_pkt(0, 0, 1); push_pkt(3, 0, 1);
    drive();
    g = 0; first_tid = -1;
    while (exp_q.size() != 0 && g < 20) begin
      tick(); g++;
      if (beat_now && first_tid < 0) first_tid = last_tid;
    end
    n_cmp++;
    if (first_tid !== 0 || beats !== 2) begin
      n_err++; $display("FAIL rst_regrant: got first tid=%0d beats=%0d, expected tid=0 beats=2", first_tid, beats);
    end
  endtask

  initial begin
    port_en = 4'hF; m_tready = 1'b1; m_hready = 1'b1;
    p3_en = 3'b000; s3_tdata = '0; s3_tkeep = '0; s3_tdest = '0; s3_tuser = '0;
    s3_tlast = '0; s3_tvalid = '0; s3_hdr = '0; s3_hvalid = '0;
    m3_tready = 1'b0; m3_hready = 1'b0;
    beat_now = 1'b0; last_tid = -1; rdy_seen = '0;
    for (int p = 0; p < P; p++) hr_cnt[p] = 0;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_wrap();
    test_backpressure();
    test_port_enable();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
